// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/load producers and the regfile write-port arbiter.
// The master side drives requests and forwarding queries; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_reg;
  logic [DW-1:0] mem_data;

  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;

  logic [AW-1:0] fwd_reg1;
  logic [AW-1:0] fwd_reg2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;

  logic [CW-1:0] count;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output fwd_reg1, fwd_reg2,
    input  mem_ready, wr_en, wr_reg, wr_data,
    input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  fwd_reg1, fwd_reg2,
    output mem_ready, wr_en, wr_reg, wr_data,
    output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: ALU writes bypass, load writes queue in a FIFO drained in idle slots.
// Define WB_FWD_EN to build the forwarding search; otherwise the fwd outputs are tied to zero.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    r_fifo_reg  [DEPTH];
  logic [DW-1:0]    r_fifo_data [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_reg;
  logic [DW-1:0]    r_wr_data;

  logic             w_alu_acc;
  logic             w_mem_ready;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_occ;

  assign w_alu_acc   = bus.alu_valid && (bus.alu_reg != '0);
  assign w_mem_ready = r_count < CW'(DEPTH);
  // Reg-0 loads complete the handshake but are never queued.
  assign w_push      = bus.mem_valid && w_mem_ready && (bus.mem_reg != '0);
  assign w_pop       = !w_alu_acc && (r_count != '0);

  always_comb begin
    logic [PW-1:0] off;
    off   = '0;
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - r_rptr;
      w_occ[i] = CW'(off) < r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_kill    <= '0;
    end else begin
      if (w_alu_acc) begin
        r_wr_en   <= 1'b1;
        r_wr_reg  <= bus.alu_reg;
        r_wr_data <= bus.alu_data;
      end else if (w_pop) begin
        // A killed head still consumes the slot, just without a write.
        r_wr_en <= !r_kill[r_rptr];
        if (!r_kill[r_rptr]) begin
          r_wr_reg  <= r_fifo_reg[r_rptr];
          r_wr_data <= r_fifo_data[r_rptr];
        end
        r_rptr <= r_rptr + PW'(1);
      end else begin
        r_wr_en <= 1'b0;
      end

      if (w_alu_acc) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_occ[i] && (r_fifo_reg[i] == bus.alu_reg)) r_kill[i] <= 1'b1;
        end
      end

      if (w_push) begin
        r_fifo_reg[r_wptr]  <= bus.mem_reg;
        r_fifo_data[r_wptr] <= bus.mem_data;
        // Same-cycle load is older than the accepted ALU write.
        r_kill[r_wptr]      <= w_alu_acc && (bus.mem_reg == bus.alu_reg);
        r_wptr              <= r_wptr + PW'(1);
      end

      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef WB_FWD_EN
  logic          w_hit1;
  logic          w_hit2;
  logic [DW-1:0] w_data1;
  logic [DW-1:0] w_data2;

  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    w_data1 = '0;
    w_data2 = '0;
    if (r_wr_en && (r_wr_reg == bus.fwd_reg1)) begin
      w_hit1  = 1'b1;
      w_data1 = r_wr_data;
    end
    if (r_wr_en && (r_wr_reg == bus.fwd_reg2)) begin
      w_hit2  = 1'b1;
      w_data2 = r_wr_data;
    end
    // Walk oldest to youngest so the youngest live match overrides.
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && !r_kill[idx]) begin
        if (r_fifo_reg[idx] == bus.fwd_reg1) begin
          w_hit1  = 1'b1;
          w_data1 = r_fifo_data[idx];
        end
        if (r_fifo_reg[idx] == bus.fwd_reg2) begin
          w_hit2  = 1'b1;
          w_data2 = r_fifo_data[idx];
        end
      end
    end
    if (bus.fwd_reg1 == '0) begin
      w_hit1  = 1'b0;
      w_data1 = '0;
    end
    if (bus.fwd_reg2 == '0) begin
      w_hit2  = 1'b0;
      w_data2 = '0;
    end
  end

  assign bus.fwd_hit1  = w_hit1;
  assign bus.fwd_data1 = w_data1;
  assign bus.fwd_hit2  = w_hit2;
  assign bus.fwd_data2 = w_data2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd  = ^{bus.fwd_reg1, bus.fwd_reg2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data2 = '0;
`endif

  assign bus.mem_ready = w_mem_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_reg    = r_wr_reg;
  assign bus.wr_data   = r_wr_data;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_regfile_wb_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    bit            killed;
  } ent_t;

  ent_t          mq[$];
  bit            m_en;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;
  int            n_total = 0;
  int            n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending values, youngest first: live queued loads, then the issued write.
  function automatic void model_fwd(input logic [AW-1:0] q, output bit hit,
                                    output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_FWD_EN
    if (q != '0) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!mq[k].killed && mq[k].r == q) begin
          hit = 1'b1;
          d   = mq[k].d;
          break;
        end
      end
      if (!hit && m_en && m_reg == q) begin
        hit = 1'b1;
        d   = m_data;
      end
    end
`endif
  endfunction

  task automatic check_outputs();
    bit            h;
    logic [DW-1:0] d;
    check("wr_en", bus.wr_en, m_en);
    if (m_en) begin
      check("wr_reg", bus.wr_reg, m_reg);
      check("wr_data", bus.wr_data, m_data);
    end
    check("count", bus.count, mq.size());
    check("mem_ready", bus.mem_ready, mq.size() < DEPTH);
    model_fwd(bus.fwd_reg1, h, d);
    check("fwd_hit1", bus.fwd_hit1, h);
    check("fwd_data1", bus.fwd_data1, d);
    model_fwd(bus.fwd_reg2, h, d);
    check("fwd_hit2", bus.fwd_hit2, h);
    check("fwd_data2", bus.fwd_data2, d);
  endtask

  task automatic model_reset();
    mq.delete();
    m_en   = 1'b0;
    m_reg  = '0;
    m_data = '0;
  endtask

  task automatic model_step();
    bit   acc;
    bit   ready;
    ent_t e;
    if (rst) begin
      model_reset();
    end else begin
      acc   = bus.alu_valid && bus.alu_reg != '0;
      ready = mq.size() < DEPTH;
      if (acc) begin
        foreach (mq[k]) if (mq[k].r == bus.alu_reg) mq[k].killed = 1'b1;
        m_en   = 1'b1;
        m_reg  = bus.alu_reg;
        m_data = bus.alu_data;
      end else if (mq.size() > 0) begin
        e    = mq.pop_front();
        m_en = !e.killed;
        if (!e.killed) begin
          m_reg  = e.r;
          m_data = e.d;
        end
      end else begin
        m_en = 1'b0;
      end
      if (bus.mem_valid && ready && bus.mem_reg != '0)
        mq.push_back('{bus.mem_reg, bus.mem_data, acc && (bus.mem_reg == bus.alu_reg)});
    end
  endtask

  // Inputs are set just after a rising edge; check, advance the model, then cross the edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_reg   = '0;
    bus.mem_data  = '0;
  endtask

  task automatic alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_reg   = r;
    bus.alu_data  = d;
  endtask

  task automatic mem(input logic [AW-1:0] r, input logic [DW-1:0] d);
    bus.mem_valid = 1'b1;
    bus.mem_reg   = r;
    bus.mem_data  = d;
  endtask

  initial begin
    idle();
    bus.fwd_reg1 = 4'd5;
    bus.fwd_reg2 = 4'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state after idle cycles
    repeat (3) tick();
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_mem_ready", bus.mem_ready, 1'b1);
    check("rst_fwd_hit1", bus.fwd_hit1, 1'b0);

    // Single ALU write
    alu(4'd5, 32'hAAAA0001);
    tick();
    idle();
    check("alu_wr_en", bus.wr_en, 1'b1);
    check("alu_wr_reg", bus.wr_reg, 4'd5);
    check("alu_wr_data", bus.wr_data, 32'hAAAA0001);

    // Fill FIFO under continuous ALU traffic, then drain in order
    for (int k = 1; k <= 4; k++) begin
      alu(4'd9, 32'h900 + k);
      mem(AW'(k), 32'h100 + k);
      tick();
    end
    idle();
    check("full_count", bus.count, 4);
    check("full_mem_ready", bus.mem_ready, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("drain_wr_en", bus.wr_en, 1'b1);
      check("drain_wr_reg", bus.wr_reg, k);
      check("drain_wr_data", bus.wr_data, 32'h100 + k);
    end
    check("drain_count", bus.count, 0);

    // Load to r3 killed by a younger ALU write to r3
    mem(4'd3, 32'h33);
    tick();
    idle();
    alu(4'd3, 32'h77);
    bus.fwd_reg1 = 4'd3;
    tick();
    idle();
    check("kill_wr_en", bus.wr_en, 1'b1);
    check("kill_wr_reg", bus.wr_reg, 4'd3);
    check("kill_wr_data", bus.wr_data, 32'h77);
    check("kill_count", bus.count, 1);
`ifdef WB_FWD_EN
    check("kill_fwd_hit1", bus.fwd_hit1, 1'b1);
    check("kill_fwd_data1", bus.fwd_data1, 32'h77);
`endif
    tick();
    check("kill_slot_wr_en", bus.wr_en, 1'b0);
    check("kill_slot_count", bus.count, 0);

    // Two loads to r7 queued behind ALU traffic; youngest forwards
    alu(4'd9, 32'h99);
    mem(4'd7, 32'h10);
    tick();
    mem(4'd7, 32'h20);
    tick();
    bus.mem_valid = 1'b0;
    bus.fwd_reg2  = 4'd7;
    #1;
    check("two_count", bus.count, 2);
`ifdef WB_FWD_EN
    check("fwd_hit2_young", bus.fwd_hit2, 1'b1);
    check("fwd_data2_young", bus.fwd_data2, 32'h20);
`endif
    idle();
    repeat (3) tick();

    // Register-zero requests
    mem(4'd0, 32'hDEAD);
    #1;
    check("r0_mem_ready", bus.mem_ready, 1'b1);
    tick();
    idle();
    check("r0_mem_count", bus.count, 0);
    alu(4'd5, 32'h55);
    tick();
    alu(4'd0, 32'hBEEF);
    tick();
    idle();
    check("r0_alu_wr_en", bus.wr_en, 1'b0);
    bus.fwd_reg1 = 4'd0;
    #1;
    check("r0_fwd_hit1", bus.fwd_hit1, 1'b0);

    // Reset while entries are queued: nothing is issued afterwards
    for (int k = 1; k <= 3; k++) begin
      alu(4'd9, 32'h0);
      mem(AW'(k + 10), 32'hC0 + k);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_wr_en", bus.wr_en, 1'b0);
    tick();
    check("post_rst_wr_en", bus.wr_en, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      bus.alu_valid = ($urandom_range(0, 99) < 45);
      bus.alu_reg   = AW'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.mem_valid = ($urandom_range(0, 99) < 70);
      bus.mem_reg   = AW'($urandom_range(0, 7));
      bus.mem_data  = $urandom;
      bus.fwd_reg1  = AW'($urandom_range(0, 7));
      bus.fwd_reg2  = AW'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back initiator for the 16x32 register file: drives its single write port (regwrite, WriteReg, WriteData) from two producers.
- Producer 1 is the ALU result path; producer 2 is the memory-load return path.
- ALU writes have priority and bypass the queue. Memory writes are buffered in a small FIFO and drained in idle slots.
- Also provides a forwarding lookup so the decode stage sees values not yet committed to the register file.

Parameters:
- DEPTH, 4, memory-write FIFO entries; power of two, >=2.
- AW, 4, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU write request; always accepted
- alu_reg  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  memory write request
- mem_ready  out  1  FIFO can accept; = (count < DEPTH)
- mem_reg  in  AW  memory destination register
- mem_data  in  DW  load data
- wr_en  out  1  to regfile regwrite (registered)
- wr_reg  out  AW  to regfile WriteReg (registered)
- wr_data  out  DW  to regfile WriteData (registered)
- fwd_reg1  in  AW  forwarding query, port 1
- fwd_reg2  in  AW  forwarding query, port 2
- fwd_hit1  out  1  pending value exists for fwd_reg1
- fwd_data1  out  DW  youngest pending value for fwd_reg1
- fwd_hit2  out  1  pending value exists for fwd_reg2
- fwd_data2  out  DW  youngest pending value for fwd_reg2
- count  out  $clog2(DEPTH)+1  FIFO occupancy, including killed entries

Behaviour:
- Reset (synchronous, overrides everything in the same cycle):
  - wr_en=0, wr_reg=0, wr_data=0, count=0, FIFO pointers=0, all kill bits clear.
  - mem_ready=1 in the first cycle after reset.
  - A reset mid-drain discards all queued entries; no write is issued.
- Output stage: registered; a request is presented at the regfile one cycle after acceptance.
- Slot selection, evaluated each cycle:
  1. If alu_valid && alu_reg!=0: load output stage with ALU write, wr_en=1.
  2. Else if count>0: pop FIFO head. wr_en=1 only if the head is not killed, else wr_en=0 (slot consumed).
  3. Else: wr_en=0; wr_reg/wr_data hold their previous values.
- Memory handshake:
  - Push on mem_valid && mem_ready.
  - mem_ready reflects count at cycle start. When full, a same-cycle pop does not enable a push.
  - mem_reg==0: handshake completes, nothing is pushed, count unchanged.
- Push and pop in the same cycle: count unchanged; both pointers advance and wrap modulo DEPTH.
- Kill rule (ALU result is architecturally younger):
  - When an ALU write to R is accepted, set the kill bit on every valid FIFO entry with reg==R.
  - This includes an entry pushed in the same cycle: same-cycle MEM is treated as older.
- ALU writes to reg 0 are ignored: not issued, nothing killed.
- Forwarding (combinational):
  - fwd_hitN=0 if fwd_regN==0.
  - Otherwise search live (unkilled) FIFO entries youngest-first. Then search the output stage, matching only when wr_en=1.
  - First match wins. No match: hit=0, data=0.
  - Current-cycle alu_*/mem_* inputs are not forwarded.
- Starvation: continuous ALU traffic can stall the FIFO indefinitely. mem_ready drops at full; upstream must stall.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: forwarding logic as specified above.
- Undefined: fwd_hit1/2=0 and fwd_data1/2=0 constantly; fwd_reg inputs unused; no search logic synthesised.

Test Plan:
- Reset, then idle 3 cycles -> wr_en=0, count=0, mem_ready=1, fwd_hit1=0.
- alu_valid, alu_reg=5, alu_data=0xAAAA0001 -> next cycle wr_en=1, wr_reg=5, wr_data=0xAAAA0001.
- Push mem writes to r1..r4 (DEPTH=4) with alu_valid=1 to r9 each cycle:
  - After 4 pushes, count=4 and mem_ready=0.
  - Drop alu_valid -> r1..r4 issued on 4 consecutive cycles, in order; count returns to 0.
- Push mem r3=0x33, then ALU r3=0x77:
  - Regfile sees r3=0x77 only.
  - The killed entry gives one wr_en=0 drain slot.
  - fwd_reg1=3 -> fwd_data1=0x77.
- Push mem r7=0x10 then r7=0x20 while ALU busy -> fwd_reg2=7 gives fwd_hit2=1, fwd_data2=0x20.
- Reg-0 writes:
  - mem_reg=0 -> handshake completes, count stays 0.
  - alu_reg=0 -> wr_en stays 0.
  - fwd_reg1=0 -> fwd_hit1=0.
